// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO buffer and its serial transmit stage.
package fifo_pkg;

  // Word width and depth shared with the stack/FIFO buffer block.
  localparam int DEF_WIDTH = 8;
  localparam int DEF_DEPTH = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACK    = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
    PARITY = 3'd4,
    STOP   = 3'd5
  } tx_state_t;

endpackage

// File: rtl/fifo_uart_tx_bit_timer.sv
// Bit-period timer: counts clk cycles while enabled, pulses bit_tick on the
// last cycle of each serial bit, and parks at zero when disabled.
module bit_timer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic bit_tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] TC = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  // Cycle counter: wraps at terminal count, cleared whenever disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (!en || cnt == TC) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign bit_tick = en && (cnt == TC);

endmodule

// File: rtl/fifo_uart_tx.sv
// Serial transmitter fed from the FIFO buffer over a four-phase pop handshake.
//
//   state  | meaning
//   IDLE   | line high, waiting for rx_rdy; captures the word on rx_rdy
//   ACK    | rx_done held high until the buffer drops rx_rdy
//   START  | start bit (line low)
//   DATA   | WIDTH data bits, LSB first
//   PARITY | even-parity bit (only when PARITY_EN=1)
//   STOP   | stop bit (line high), then back to IDLE
module fifo_uart_tx
  import fifo_pkg::*;
#(
  parameter int WIDTH        = DEF_WIDTH,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_rdy,
  output logic             rx_done,
  input  logic [WIDTH-1:0] in_data,
  output logic             tx_line,
  output logic             busy
);

  localparam int BCW = $clog2(WIDTH + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

  tx_state_t        state, state_nxt;
  logic [WIDTH-1:0] shift_q, shift_nxt;
  logic             parity_q;
  logic [BCW-1:0]   bit_cnt;
  logic             tick, timer_en;
  logic             tx_nxt, done_nxt, busy_nxt;

  assign timer_en = (state == START) || (state == DATA) ||
                    (state == PARITY) || (state == STOP);

  bit_timer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_bit_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (timer_en),
    .bit_tick (tick)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state and next shift-register contents.
  always_comb begin
    state_nxt = state;
    shift_nxt = shift_q;
    unique case (state)
      IDLE: if (rx_rdy) begin
        state_nxt = ACK;
        shift_nxt = in_data;
      end
      ACK:    if (!rx_rdy) state_nxt = START;
      START:  if (tick) state_nxt = DATA;
      DATA: if (tick) begin
        shift_nxt = shift_q >> 1;
        if (bit_cnt == LAST_BIT) state_nxt = (PARITY_EN != 0) ? PARITY : STOP;
      end
      PARITY: if (tick) state_nxt = STOP;
      STOP:   if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output values for the coming cycle, derived from the next state so the
  // registered outputs line up with the state they belong to.
  always_comb begin
    tx_nxt   = 1'b1;
    done_nxt = 1'b0;
    busy_nxt = 1'b1;
    unique case (state_nxt)
      IDLE:    busy_nxt = 1'b0;
      ACK:     done_nxt = 1'b1;
      START:   tx_nxt   = 1'b0;
      DATA:    tx_nxt   = shift_nxt[0];
      PARITY:  tx_nxt   = parity_q;
      STOP:    tx_nxt   = 1'b1;
      default: busy_nxt = 1'b0;
    endcase
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q  <= '0;
      parity_q <= 1'b0;
      bit_cnt  <= '0;
      tx_line  <= 1'b1;
      rx_done  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      shift_q <= shift_nxt;
      if (state == IDLE && rx_rdy) parity_q <= ^in_data;
      if (state != DATA) begin
        bit_cnt <= '0;
      end else if (tick) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + BCW'(1);
      end
      tx_line <= tx_nxt;
      rx_done <= done_nxt;
      busy    <= busy_nxt;
    end
  end

endmodule
